// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic inter-stage register: state encoding,
// payload field layout of the compact 32-bit IF/ID bus, and a mask helper.
package pipe_pkg;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    typedef enum logic [1:0] {
        EMPTY = ST_EMPTY,
        ONE   = ST_ONE,
        TWO   = ST_TWO
    } state_t;

    // Compact IF/ID payload: pc in the upper half, instruction in the lower.
    localparam int unsigned INSTR_LSB = 0;
    localparam int unsigned INSTR_W   = 16;
    localparam int unsigned PC_LSB    = 16;
    localparam int unsigned PC_W      = 16;
    localparam int unsigned BUS_W     = 32;

    // Builds a mask covering [lsb +: w] of a BUS_W-bit payload.
    function automatic logic [BUS_W-1:0] field_mask(input int unsigned lsb,
                                                    input int unsigned w);
        logic [BUS_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < BUS_W; i++) begin
            if (i >= lsb && i < lsb + w) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/pipe_stage_elastic.sv
// Elastic inter-stage register: valid/ready handshake, optional two-entry
// skid buffer, synchronous flush that masks held payload fields, and a
// saturating counter of cycles where the consumer was ready but starved.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int unsigned       DATA_W   = 32,
    parameter logic [DATA_W-1:0] CLR_MASK = {DATA_W{1'b1}},
    parameter bit                SKID     = 1'b1,
    parameter int unsigned       CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  bubble_cnt
);

    state_t            state, state_n;
    logic [DATA_W-1:0] main_q, main_n;
    logic [DATA_W-1:0] skid_q, skid_n;
    logic              in_fire, out_fire;

    assign out_valid = (state != EMPTY);
    assign out_data  = main_q;
    assign occupancy = state;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    generate
        if (SKID) begin : g_skid
            logic ready_q;
            // Registered ready: low exactly while both entries are occupied.
            always_ff @(posedge clk) begin
                if (!reset_n) ready_q <= 1'b1;
                else          ready_q <= (state_n != TWO);
            end
            assign in_ready = ready_q;
        end else begin : g_noskid
            assign in_ready = out_ready | ~out_valid;
        end
    endgenerate

    // Next-state and entry updates; flush masks whatever is held, so a
    // payload accepted in the same cycle is dropped.
    always_comb begin
        state_n = state;
        main_n  = main_q;
        skid_n  = skid_q;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    state_n = ONE;
                    main_n  = in_data;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_n = in_data;
                end else if (in_fire && SKID) begin
                    state_n = TWO;
                    skid_n  = in_data;
                end else if (out_fire) begin
                    state_n = EMPTY;
                end
            end
            TWO: begin
                if (out_fire) begin
                    state_n = ONE;
                    main_n  = skid_q;
                end
            end
            default: state_n = EMPTY;
        endcase
        if (flush) begin
            state_n = EMPTY;
            main_n  = main_q & ~CLR_MASK;
            skid_n  = skid_q & ~CLR_MASK;
        end
    end

    // State and entry registers; reset clears payload as well as control.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            state  <= state_n;
            main_q <= main_n;
            skid_q <= skid_n;
        end
    end

    // Saturating bubble counter; flush does not touch it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bubble_cnt <= '0;
        end else if (out_ready && !out_valid && (bubble_cnt != {CNT_W{1'b1}})) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: skid instance (masked flush, 2-bit counter)
// and a no-skid instance, table-driven vectors plus a FIFO scoreboard.
module tb_pipe_stage_elastic;
    import pipe_pkg::*;

    logic        clk;
    logic        reset_n;
    // skid instance
    logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [31:0] a_in_data, a_out_data;
    logic [1:0]  a_occ;
    logic [1:0]  a_bubble;
    // no-skid instance
    logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [31:0] b_in_data, b_out_data;
    logic [1:0]  b_occ;
    logic [15:0] b_bubble;

    int checks = 0;
    int errors = 0;

    logic [31:0] q_a[$];
    logic [31:0] q_b[$];

    pipe_stage_elastic #(
        .DATA_W(32), .CLR_MASK(field_mask(PC_LSB, PC_W)), .SKID(1'b1), .CNT_W(2)
    ) u_a (
        .clk(clk), .reset_n(reset_n), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .occupancy(a_occ), .bubble_cnt(a_bubble)
    );

    pipe_stage_elastic #(
        .DATA_W(32), .SKID(1'b0), .CNT_W(16)
    ) u_b (
        .clk(clk), .reset_n(reset_n), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .occupancy(b_occ), .bubble_cnt(b_bubble)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard for the skid instance, sampled mid-cycle ahead of the edge.
    always @(negedge clk) begin
        if (!reset_n) begin
            q_a.delete();
        end else begin
            if (a_out_valid && a_out_ready) begin
                if (q_a.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_a_spurious: got %0h, expected no output", a_out_data);
                end else begin
                    chk("sb_a_order", a_out_data, q_a.pop_front());
                end
            end
            if (a_flush) q_a.delete();
            else if (a_in_valid && a_in_ready) q_a.push_back(a_in_data);
        end
    end

    // Scoreboard for the no-skid instance.
    always @(negedge clk) begin
        if (!reset_n) begin
            q_b.delete();
        end else begin
            if (b_out_valid && b_out_ready) begin
                if (q_b.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_b_spurious: got %0h, expected no output", b_out_data);
                end else begin
                    chk("sb_b_order", b_out_data, q_b.pop_front());
                end
            end
            if (b_flush) q_b.delete();
            else if (b_in_valid && b_in_ready) q_b.push_back(b_in_data);
        end
    end

    typedef struct {
        logic        vld;
        logic [31:0] data;
        logic        ordy;
        logic        fl;
        logic        ov;
        logic [31:0] od;
        logic [1:0]  occ;
        logic        ir;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs[NV];

    initial begin
        // streaming 1..4 at full rate
        vecs[0]  = '{1'b1, 32'd1, 1'b1, 1'b0, 1'b1, 32'd1, 2'd1, 1'b1};
        vecs[1]  = '{1'b1, 32'd2, 1'b1, 1'b0, 1'b1, 32'd2, 2'd1, 1'b1};
        vecs[2]  = '{1'b1, 32'd3, 1'b1, 1'b0, 1'b1, 32'd3, 2'd1, 1'b1};
        vecs[3]  = '{1'b1, 32'd4, 1'b1, 1'b0, 1'b1, 32'd4, 2'd1, 1'b1};
        vecs[4]  = '{1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd4, 2'd0, 1'b1};
        // back-pressure: A, B fill both entries, C held off, then drain
        vecs[5]  = '{1'b1, 32'hA0A0_0001, 1'b0, 1'b0, 1'b1, 32'hA0A0_0001, 2'd1, 1'b1};
        vecs[6]  = '{1'b1, 32'hB0B0_0002, 1'b0, 1'b0, 1'b1, 32'hA0A0_0001, 2'd2, 1'b0};
        vecs[7]  = '{1'b1, 32'hC0C0_0003, 1'b0, 1'b0, 1'b1, 32'hA0A0_0001, 2'd2, 1'b0};
        vecs[8]  = '{1'b1, 32'hC0C0_0003, 1'b1, 1'b0, 1'b1, 32'hB0B0_0002, 2'd1, 1'b1};
        vecs[9]  = '{1'b1, 32'hC0C0_0003, 1'b1, 1'b0, 1'b1, 32'hC0C0_0003, 2'd1, 1'b1};
        vecs[10] = '{1'b0, 32'd0,         1'b1, 1'b0, 1'b0, 32'hC0C0_0003, 2'd0, 1'b1};
        // flush from TWO with a same-cycle input offer of 9
        vecs[11] = '{1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 2'd1, 1'b1};
        vecs[12] = '{1'b1, 32'hAAAA_BBBB, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 2'd2, 1'b0};
        vecs[13] = '{1'b1, 32'd9,         1'b0, 1'b1, 1'b0, 32'h0000_5678, 2'd0, 1'b1};
        vecs[14] = '{1'b0, 32'd0,         1'b1, 1'b0, 1'b0, 32'h0000_5678, 2'd0, 1'b1};
        // flush from ONE with simultaneous in_fire and out_fire
        vecs[15] = '{1'b1, 32'hFFFF_0055, 1'b0, 1'b0, 1'b1, 32'hFFFF_0055, 2'd1, 1'b1};
        vecs[16] = '{1'b1, 32'd9,         1'b1, 1'b1, 1'b0, 32'h0000_0055, 2'd0, 1'b1};
        vecs[17] = '{1'b0, 32'd0,         1'b1, 1'b0, 1'b0, 32'h0000_0055, 2'd0, 1'b1};
    end

    initial begin
        reset_n = 1'b0;
        a_flush = 1'b0; a_in_valid = 1'b1; a_in_data = 32'hDEAD_BEEF; a_out_ready = 1'b0;
        b_flush = 1'b0; b_in_valid = 1'b1; b_in_data = 32'hDEAD_BEEF; b_out_ready = 1'b0;

        // reset held for two edges with an offered payload
        tick();
        tick();
        chk("rst_a_out_valid", 32'(a_out_valid), 32'd0);
        chk("rst_a_out_data",  a_out_data, 32'd0);
        chk("rst_a_occupancy", 32'(a_occ), 32'd0);
        chk("rst_a_bubble",    32'(a_bubble), 32'd0);
        chk("rst_a_in_ready",  32'(a_in_ready), 32'd1);
        chk("rst_b_out_valid", 32'(b_out_valid), 32'd0);
        chk("rst_b_out_data",  b_out_data, 32'd0);
        chk("rst_b_bubble",    32'(b_bubble), 32'd0);

        // bubble counter saturates at 3 for a 2-bit width
        reset_n = 1'b1;
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("bubble_%0d", i), 32'(a_bubble), (i < 3) ? 32'(i + 1) : 32'd3);
        end
        a_flush = 1'b1;
        tick();
        chk("bubble_after_flush", 32'(a_bubble), 32'd3);
        a_flush = 1'b0;

        // vector table on the skid instance
        for (int i = 0; i < NV; i++) begin
            a_in_valid  = vecs[i].vld;
            a_in_data   = vecs[i].data;
            a_out_ready = vecs[i].ordy;
            a_flush     = vecs[i].fl;
            tick();
            chk($sformatf("v%0d_out_valid", i), 32'(a_out_valid), 32'(vecs[i].ov));
            chk($sformatf("v%0d_out_data", i),  a_out_data, vecs[i].od);
            chk($sformatf("v%0d_occupancy", i), 32'(a_occ), 32'(vecs[i].occ));
            chk($sformatf("v%0d_in_ready", i),  32'(a_in_ready), 32'(vecs[i].ir));
        end
        a_in_valid = 1'b0; a_flush = 1'b0; a_out_ready = 1'b0;

        // no-skid instance: combinational ready and same-cycle pass-through
        b_in_valid = 1'b1; b_in_data = 32'h11; b_out_ready = 1'b0;
        #1;
        chk("b_ready_empty", 32'(b_in_ready), 32'd1);
        tick();
        chk("b_one_out_data", b_out_data, 32'h11);
        chk("b_full_ready",   32'(b_in_ready), 32'd0);
        b_in_data = 32'h22;
        tick();
        chk("b_held_out_data", b_out_data, 32'h11);
        chk("b_held_occ",      32'(b_occ), 32'd1);
        b_out_ready = 1'b1;
        #1;
        chk("b_ready_comb", 32'(b_in_ready), 32'd1);
        tick();
        chk("b_pass_out_data", b_out_data, 32'h22);
        chk("b_pass_occ",      32'(b_occ), 32'd1);
        b_in_valid = 1'b0;
        tick();
        chk("b_drain_valid", 32'(b_out_valid), 32'd0);
        b_out_ready = 1'b0;

        tick();
        chk("sb_a_drained", 32'(q_a.size()), 32'd0);
        chk("sb_b_drained", 32'(q_b.size()), 32'd0);

        // reset in the middle of a transfer drops the held entry
        a_in_valid = 1'b1; a_in_data = 32'h77;
        tick();
        chk("mid_loaded_occ", 32'(a_occ), 32'd1);
        reset_n = 1'b0;
        tick();
        chk("mid_rst_occ",       32'(a_occ), 32'd0);
        chk("mid_rst_out_valid", 32'(a_out_valid), 32'd0);
        chk("mid_rst_out_data",  a_out_data, 32'd0);
        chk("mid_rst_bubble",    32'(a_bubble), 32'd0);
        reset_n = 1'b1; a_in_valid = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
